// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, req/ack fetch from instruction memory,
// branch redirect. Optional performance counters enabled with IFETCH_PERF_EN.
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] instruction,
   output logic [5:0]  opcode,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   input  logic        branch,
   input  logic        zero
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`endif
);

   localparam logic [31:0] ALIGNED_RESET_PC = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_VALID
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_pc;
   logic [31:0] r_instruction;
   logic        r_req;
   logic        r_valid;
   logic        w_capture;
   logic        w_accept;
   logic        w_taken;
   logic [31:0] w_target;
   logic [31:0] w_nextPc;

   always_comb begin
      w_nextState = r_state;
      w_capture   = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_nextState = S_REQ;
         end
         S_REQ: begin
            if (imem_ack) begin
               w_capture   = 1'b1;
               w_nextState = S_VALID;
            end
         end
         S_VALID: begin
            if (inst_ready) begin
               w_accept    = 1'b1;
               w_nextState = S_REQ;
            end
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Branch offset is the sign-extended word offset relative to the next sequential PC.
   assign w_target = r_pc + 32'd4 + {{14{r_instruction[15]}}, r_instruction[15:0], 2'b00};
   assign w_taken  = branch & zero;
   assign w_nextPc = w_taken ? w_target : (r_pc + 32'd4);

   // Request and valid flags are registered from the next state so they stay glitch-free.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_pc          <= ALIGNED_RESET_PC;
         r_instruction <= 32'd0;
         r_req         <= 1'b0;
         r_valid       <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_req   <= (w_nextState == S_REQ);
         r_valid <= (w_nextState == S_VALID);
         if (w_capture) begin
            r_instruction <= imem_rdata;
         end
         if (w_accept) begin
            r_pc <= w_nextPc;
         end
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign inst_valid  = r_valid;
   assign instruction = r_instruction;
   assign opcode      = r_instruction[31:26];
   assign pc_out      = r_pc;
   assign pc_plus4    = r_pc + 32'd4;

`ifdef IFETCH_PERF_EN
   logic [31:0] r_fetchCount;
   logic [31:0] r_stallCount;

   // A stall is any cycle spent waiting on memory or on the consumer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_fetchCount <= 32'd0;
         r_stallCount <= 32'd0;
      end else begin
         if (w_capture) begin
            r_fetchCount <= r_fetchCount + 32'd1;
         end
         if (((r_state == S_REQ) && !imem_ack) || ((r_state == S_VALID) && !inst_ready)) begin
            r_stallCount <= r_stallCount + 32'd1;
         end
      end
   end

   assign fetch_count = r_fetchCount;
   assign stall_count = r_stallCount;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: vector table, randomized fetches against a
// PC model, and reset-during-fetch sequences.
module tb_ifetch;

   logic        clock;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] instruction;
   logic [5:0]  opcode;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        branch;
   logic        zero;

   logic        altReq;
   logic [31:0] altAddr;
   logic        altValid;
   logic [31:0] altInstruction;
   logic [5:0]  altOpcode;
   logic [31:0] altPcOut;
   logic [31:0] altPcPlus4;

`ifdef IFETCH_PERF_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
   logic [31:0] altFetchCount;
   logic [31:0] altStallCount;
`endif

   int          errors = 0;
   int          checks = 0;
   logic [31:0] modelPc;
   logic [31:0] modelFetch;
   logic [31:0] modelStall;

   typedef struct {
      logic [31:0] addr;
      int          ackDelay;
      logic [31:0] word;
      int          readyDelay;
      logic        br;
      logic        zr;
      logic [31:0] next;
   } vec_t;

   vec_t vecs[14];

   ifetch u_dut (
      .clock       (clock),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .instruction (instruction),
      .opcode      (opcode),
      .pc_out      (pc_out),
      .pc_plus4    (pc_plus4),
      .branch      (branch),
      .zero        (zero)
`ifdef IFETCH_PERF_EN
      ,
      .fetch_count (fetch_count),
      .stall_count (stall_count)
`endif
   );

   ifetch #(.RESET_PC(32'h0000_1003)) u_alt (
      .clock       (clock),
      .reset       (reset),
      .imem_req    (altReq),
      .imem_addr   (altAddr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .inst_valid  (altValid),
      .inst_ready  (inst_ready),
      .instruction (altInstruction),
      .opcode      (altOpcode),
      .pc_out      (altPcOut),
      .pc_plus4    (altPcPlus4),
      .branch      (branch),
      .zero        (zero)
`ifdef IFETCH_PERF_EN
      ,
      .fetch_count (altFetchCount),
      .stall_count (altStallCount)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic checkCounters();
`ifdef IFETCH_PERF_EN
      checkOutput("fetchCount", fetch_count, modelFetch);
      checkOutput("stallCount", stall_count, modelStall);
`endif
   endtask

   // Asserts reset now, releases it two cycles later with ackAfter driven in the IDLE cycle.
   task automatic resetDut(input logic ackAfter);
      reset = 1'b1;
      #1;
      checkOutput("rstReq", imem_req, 1'b0);
      checkOutput("rstAddr", imem_addr, 32'h0);
      checkOutput("rstValid", inst_valid, 1'b0);
      checkOutput("rstInstr", instruction, 32'h0);
      checkOutput("rstOpcode", opcode, 6'h0);
      checkOutput("rstPcOut", pc_out, 32'h0);
      checkOutput("rstPcPlus4", pc_plus4, 32'h4);
      checkOutput("altRstAddr", altAddr, 32'h0000_1000);
      checkOutput("altRstPcPlus4", altPcPlus4, 32'h0000_1004);
      modelPc    = 32'h0;
      modelFetch = 32'h0;
      modelStall = 32'h0;
      checkCounters();
      @(negedge clock);
      @(negedge clock);
      reset      = 1'b0;
      imem_ack   = ackAfter;
      imem_rdata = 32'hDEAD_BEEF;
      #1;
      checkOutput("idleReq", imem_req, 1'b0);
      @(negedge clock);
      imem_ack = 1'b0;
      checkOutput("postIdleValid", inst_valid, 1'b0);
      checkOutput("postIdleInstr", instruction, 32'h0);
      checkOutput("postIdleReq", imem_req, 1'b1);
      checkOutput("postIdleAddr", imem_addr, 32'h0);
   endtask

   // One complete fetch: wait for request, ack after ackDelay, hold VALID readyDelay cycles, accept.
   task automatic applyStimulus(input int ackDelay, input logic [31:0] word, input int readyDelay,
                                input logic br, input logic zr, input int expWait);
      int          n;
      int signed   imm;
      n = 0;
      while (imem_req !== 1'b1 && n < 8) begin
         @(negedge clock);
         n++;
      end
      if (expWait >= 0) checkOutput("reqLatency", n, expWait);
      checkOutput("imemReq", imem_req, 1'b1);
      checkOutput("imemAddr", imem_addr, modelPc);
      checkOutput("validInReq", inst_valid, 1'b0);
      for (int i = 0; i < ackDelay; i++) begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         @(negedge clock);
         checkOutput("reqHold", imem_req, 1'b1);
         checkOutput("addrHold", imem_addr, modelPc);
         checkOutput("noEarlyValid", inst_valid, 1'b0);
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(negedge clock);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      checkOutput("instValid", inst_valid, 1'b1);
      checkOutput("instruction", instruction, word);
      checkOutput("opcode", opcode, word >> 26);
      checkOutput("pcOut", pc_out, modelPc);
      checkOutput("pcPlus4", pc_plus4, modelPc + 32'd4);
      checkOutput("reqInValid", imem_req, 1'b0);
      for (int i = 0; i < readyDelay; i++) begin
         inst_ready = 1'b0;
         branch     = 1'($urandom);
         zero       = 1'($urandom);
         imem_ack   = 1'($urandom);
         imem_rdata = $urandom;
         @(negedge clock);
         checkOutput("stallValid", inst_valid, 1'b1);
         checkOutput("stallInstr", instruction, word);
         checkOutput("stallPcOut", pc_out, modelPc);
         checkOutput("stallNoReq", imem_req, 1'b0);
      end
      imem_ack   = 1'b0;
      inst_ready = 1'b1;
      branch     = br;
      zero       = zr;
      @(negedge clock);
      inst_ready = 1'b0;
      branch     = 1'b0;
      zero       = 1'b0;
      imm        = $signed(word[15:0]);
      modelFetch = modelFetch + 32'd1;
      modelStall = modelStall + 32'(ackDelay) + 32'(readyDelay);
      if (br && zr) modelPc = modelPc + 32'd4 + 32'(imm * 4);
      else          modelPc = modelPc + 32'd4;
      checkOutput("validDrop", inst_valid, 1'b0);
      checkCounters();
   endtask

   initial begin
      reset      = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      inst_ready = 1'b0;
      branch     = 1'b0;
      zero       = 1'b0;

      //           addr          ack  word          rdy br    zr    next
      vecs[0]  = '{32'h0000_0000, 0, 32'h2001_0005, 0, 1'b0, 1'b0, 32'h0000_0004};
      vecs[1]  = '{32'h0000_0004, 0, 32'h8C22_0000, 0, 1'b0, 1'b1, 32'h0000_0008};
      vecs[2]  = '{32'h0000_0008, 0, 32'hAC22_0004, 0, 1'b1, 1'b0, 32'h0000_000C};
      vecs[3]  = '{32'h0000_000C, 3, 32'h0000_0020, 0, 1'b0, 1'b0, 32'h0000_0010};
      vecs[4]  = '{32'h0000_0010, 0, 32'h1000_000B, 0, 1'b1, 1'b1, 32'h0000_0040};
      vecs[5]  = '{32'h0000_0040, 0, 32'h1000_FFFF, 0, 1'b1, 1'b1, 32'h0000_0040};
      vecs[6]  = '{32'h0000_0040, 1, 32'h1000_FFFF, 1, 1'b1, 1'b0, 32'h0000_0044};
      vecs[7]  = '{32'h0000_0044, 0, 32'h1000_0003, 0, 1'b0, 1'b1, 32'h0000_0048};
      vecs[8]  = '{32'h0000_0048, 0, 32'h1000_0003, 5, 1'b1, 1'b1, 32'h0000_0058};
      vecs[9]  = '{32'h0000_0058, 2, 32'h1000_FFE8, 0, 1'b1, 1'b1, 32'hFFFF_FFFC};
      vecs[10] = '{32'hFFFF_FFFC, 0, 32'h0800_0000, 0, 1'b0, 1'b0, 32'h0000_0000};
      vecs[11] = '{32'h0000_0000, 2, 32'hFFFF_FFFF, 0, 1'b1, 1'b1, 32'h0000_0000};
      vecs[12] = '{32'h0000_0000, 0, 32'h1000_8000, 1, 1'b1, 1'b1, 32'hFFFE_0004};
      vecs[13] = '{32'hFFFE_0004, 0, 32'h1000_7FFF, 0, 1'b0, 1'b1, 32'hFFFE_0008};

      resetDut(1'b0);

      foreach (vecs[i]) begin
         checkOutput("vecAddr", imem_addr, vecs[i].addr);
         applyStimulus(vecs[i].ackDelay, vecs[i].word, vecs[i].readyDelay,
                       vecs[i].br, vecs[i].zr, 0);
         checkOutput("vecNext", imem_addr, vecs[i].next);
      end

      for (int i = 0; i < 40; i++) begin
         applyStimulus(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end

      // Reset while requesting, with a stale ack arriving just after release.
      resetDut(1'b1);
      applyStimulus(0, 32'h2002_0001, 0, 1'b0, 1'b0, 0);
      checkOutput("afterRstNext", imem_addr, 32'h0000_0004);

      // Reset while an instruction is held valid.
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      @(negedge clock);
      imem_ack = 1'b0;
      checkOutput("preRstValid", inst_valid, 1'b1);
      resetDut(1'b0);
      applyStimulus(1, 32'h0C00_0010, 2, 1'b1, 1'b1, 0);
      checkOutput("finalNext", imem_addr, 32'h0000_0044);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
